// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory read scheduler.
package mem_sched_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} sched_state_e;

  localparam int ID_W = 4;

  typedef logic [7:0] age_t;

endpackage

// File: rtl/mem_sched_pick.sv
// Fixed-priority request picker (lowest index wins) with a prefetch override
// when the prefetch age counter has saturated.
module mem_sched_pick #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] valid,
  input  logic                   age_sat,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx
);

  always_comb begin
    grant = '0;
    idx   = '0;
    // Walk downward so the lowest valid index is the last one written.
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    if (age_sat && valid[NUM_MASTERS-1]) begin
      grant                = '0;
      grant[NUM_MASTERS-1] = 1'b1;
      idx                  = IDX_W'(NUM_MASTERS-1);
    end
  end

endmodule

// File: rtl/mem_read_scheduler.sv
// Single-outstanding read scheduler: arbitrates read masters onto one memory
// read channel and steers beats back by ID. Prefetch aging: MEM_SCHED_AGING_EN.
module mem_read_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int AGE_LIMIT   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*4-1:0]      m_arlen,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic                          m_rlast,
  output logic [DATA_W-1:0]             m_rdata,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ID_W-1:0]               ARID,
  output logic [3:0]                    ARLEN,
  output logic [ADDR_W-1:0]             ARADDR,
  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic                          RLAST,
  input  logic [ID_W-1:0]               RID,
  input  logic [DATA_W-1:0]             RDATA,
  output logic                          rid_err
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_bad_age_limit
    $error("mem_read_scheduler: AGE_LIMIT must be in 1..255");
  end

  sched_state_e state_q, state_d;

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_MASTERS-1:0][3:0]        len_v;
  logic [NUM_MASTERS-1:0]             grant, own_oh_q;
  logic [IDX_W-1:0]                   win_idx, own_idx_q;
  logic [ADDR_W-1:0]                  addr_q;
  logic [3:0]                         len_q;
  logic                               age_sat, take, id_match, rready_sel;

  assign addr_v = m_araddr;
  assign len_v  = m_arlen;

`ifdef MEM_SCHED_AGING_EN
  localparam int PF = NUM_MASTERS-1;
  age_t age_q;

  assign age_sat = (age_q == age_t'(AGE_LIMIT));

  // Clears on withdrawal too: a stale age must not carry into a later request.
  always_ff @(posedge clk) begin
    if (!rst_n)                              age_q <= '0;
    else if (!m_arvalid[PF] || m_arready[PF]) age_q <= '0;
    else if (!age_sat)                       age_q <= age_q + 1'b1;
  end
`else
  assign age_sat = 1'b0;
`endif

  mem_sched_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .valid  (m_arvalid),
    .age_sat(age_sat),
    .grant  (grant),
    .idx    (win_idx)
  );

  // Gated by rst_n so no request is consumed while reset is held.
  assign take      = rst_n && (state_q == IDLE) && (|m_arvalid);
  assign m_arready = take ? grant : '0;
  assign id_match  = (RID == ID_W'(own_idx_q));

  assign ARVALID = (state_q == ADDR);
  assign ARID    = ID_W'(own_idx_q);
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign m_rdata = RDATA;
  assign m_rlast = RLAST;
  assign RREADY  = rready_sel;

  always_comb begin
    state_d    = state_q;
    m_rvalid   = '0;
    rready_sel = 1'b0;
    case (state_q)
      IDLE: if (take) state_d = ADDR;
      ADDR: if (ARREADY) state_d = DATA;
      DATA: begin
        if (id_match) begin
          m_rvalid   = RVALID ? own_oh_q : '0;
          rready_sel = |(m_rready & own_oh_q);
          if (RVALID && rready_sel && RLAST) state_d = IDLE;
        end else begin
          rready_sel = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      own_idx_q <= '0;
      own_oh_q  <= '0;
      rid_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q    <= addr_v[win_idx];
        len_q     <= len_v[win_idx];
        own_idx_q <= win_idx;
        own_oh_q  <= grant;
      end
      if (state_q == DATA && RVALID && !id_match) rid_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Scoreboard bench for mem_read_scheduler: expected bursts are queued in grant
// order as requests are raised and checked against the address/data channels.
module tb_mem_read_scheduler;

  localparam int NM = 3;
  localparam int AW = 26;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NM-1:0]   m_arvalid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*4-1:0] m_arlen;
  logic [NM-1:0]   m_arready, m_rvalid, m_rready;
  logic            m_rlast;
  logic [DW-1:0]   m_rdata;
  logic            ARVALID, ARREADY, RVALID, RREADY, RLAST, rid_err;
  logic [3:0]      ARID, ARLEN, RID;
  logic [AW-1:0]   ARADDR;
  logic [DW-1:0]   RDATA;

  always #5 clk = ~clk;

  mem_read_scheduler #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rready(m_rready),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .rid_err(rid_err)
  );

  typedef struct {int m; logic [AW-1:0] a; int len;} burst_t;

  burst_t        q[$];
  burst_t        cur;
  int            n_chk = 0, n_err = 0;
  int            ph = 0, beat = 0, stall = 0, ar_cycles = 0;
  int            hold_left[NM];
  logic [AW-1:0] addr_of[NM];
  int            len_of[NM];
  bit            bad_pending = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bdata(input logic [AW-1:0] a, input int b);
    return {6'(b), a};
  endfunction

  task automatic req(input int m, input logic [AW-1:0] a, input int len);
    m_arvalid[m] = 1'b1;
    m_araddr[m*AW +: AW] = a;
    m_arlen[m*4 +: 4] = 4'(len);
    addr_of[m] = a;
    len_of[m] = len;
  endtask

  task automatic exp_g(input int m);
    q.push_back('{m: m, a: addr_of[m], len: len_of[m]});
  endtask

  // One clock: drive memory side, sample at +1, then advance the expected model.
  task automatic step();
    int ph_n, beat_n, drop;
    bit bad_now, err_n, bad_n;
    ph_n = ph; beat_n = beat; drop = -1; err_n = exp_err; bad_n = bad_pending;
    bad_now  = (ph == 2) && bad_pending;
    ARREADY  = (ph == 1) && (stall == 0);
    RVALID   = bad_now || ((ph == 2) && ($urandom_range(0, 3) != 0));
    RID      = bad_now ? 4'd2 : 4'(cur.m);
    RDATA    = bad_now ? 32'hDEAD_BEEF : bdata(cur.a, beat);
    RLAST    = bad_now ? 1'b1 : (beat == cur.len);
    m_rready = NM'($urandom);
    #1;
    chk("rid_err", rid_err, exp_err);
    chk("rdata_mirror", m_rdata, RDATA);
    chk("arready_onehot", ($countones(m_arready) <= 1), 1);
    if (ph == 0) begin
      chk("arvalid_idle", ARVALID, 0);
      if (|m_arvalid) begin
        if (q.size() == 0) chk("unexpected_grant", m_arready, 0);
        else begin
          cur = q.pop_front();
          chk("grant", m_arready, NM'(1) << cur.m);
          drop = cur.m; ph_n = 1; ar_cycles = 0;
        end
      end else chk("arready_noreq", m_arready, 0);
    end else begin
      chk("arready_busy", m_arready, 0);
    end
    if (ph == 1) begin
      ar_cycles++;
      chk("arvalid", ARVALID, 1);
      chk("arid", ARID, cur.m);
      chk("araddr", ARADDR, cur.a);
      chk("arlen", ARLEN, cur.len);
      chk("rvalid_addr", m_rvalid, 0);
      if (ARREADY) begin ph_n = 2; beat_n = 0; end
    end
    if (ph == 2) begin
      chk("arvalid_data", ARVALID, 0);
      if (bad_now) begin
        chk("bad_rvalid", m_rvalid, 0);
        chk("bad_rready", RREADY, 1);
        err_n = 1; bad_n = 0;
      end else if (RVALID) begin
        chk("rvalid_route", m_rvalid, NM'(1) << cur.m);
        chk("rready_route", RREADY, m_rready[cur.m]);
        if (RREADY) begin
          chk("rdata", m_rdata, bdata(cur.a, beat));
          chk("rlast", m_rlast, beat == cur.len);
          beat_n = beat + 1;
          if (beat == cur.len) ph_n = 0;
        end
      end else chk("rvalid_idle", m_rvalid, 0);
    end
    @(posedge clk); #1;
    if (drop >= 0) begin
      if (hold_left[drop] > 0) hold_left[drop]--;
      else m_arvalid[drop] = 1'b0;
    end
    if (ph == 1 && stall > 0) stall--;
    ph = ph_n; beat = beat_n; exp_err = err_n; bad_pending = bad_n;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || ph != 0) && n < budget) begin step(); n++; end
    chk("drain", q.size() + ph, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    ARREADY = 0; RVALID = 0; RLAST = 0; RID = '0; RDATA = '0;
    cur = '{m: 0, a: '0, len: 0};
    for (int i = 0; i < NM; i++) hold_left[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", m_arready, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_rid_err", rid_err, 0);
    rst_n = 1'b1;

    // single D-cache burst
    req(0, 26'h100, 3); exp_g(0); run(200);

    // all three at once
    req(0, 26'h1000, 1); req(1, 26'h2000, 1); req(2, 26'h3000, 1);
`ifdef MEM_SCHED_AGING_EN
    exp_g(0); exp_g(2); exp_g(1);
`else
    exp_g(0); exp_g(1); exp_g(2);
`endif
    run(300);

    // address channel stalled 5 cycles
    req(1, 26'h200, 0); exp_g(1); stall = 5; run(200);
    chk("ar_hold_cycles", ar_cycles, 6);

    // mismatched RID drained while in DATA
    req(0, 26'h500, 1); exp_g(0); bad_pending = 1; run(200);
    chk("rid_err_set", rid_err, 1);

    // prefetch starvation: master 0 held valid for three grants
    hold_left[0] = 2;
    req(0, 26'h600, 1); req(2, 26'h700, 1);
`ifdef MEM_SCHED_AGING_EN
    exp_g(0); exp_g(2); exp_g(0); exp_g(0);
`else
    exp_g(0); exp_g(0); exp_g(0); exp_g(2);
`endif
    run(500);

    // reset during DATA beat 2
    req(0, 26'h300, 7); exp_g(0);
    n = 0;
    while (!(ph == 2 && beat == 2) && n < 200) begin step(); n++; end
    chk("reach_beat2", beat, 2);
    req(1, 26'h400, 2);
    rst_n = 1'b0; RVALID = 1'b1; RID = 4'(cur.m); m_rready = '1; ARREADY = 1'b1;
    @(posedge clk); #1;
    chk("rst2_arready", m_arready, 0);
    chk("rst2_rvalid", m_rvalid, 0);
    chk("rst2_arvalid", ARVALID, 0);
    chk("rst2_rready", RREADY, 0);
    chk("rst2_arid", ARID, 0);
    chk("rst2_arlen", ARLEN, 0);
    chk("rst2_araddr", ARADDR, 0);
    chk("rst2_rid_err", rid_err, 0);
    rst_n = 1'b1;
    q.delete(); ph = 0; beat = 0; bad_pending = 0; exp_err = 0;
    exp_g(1); run(200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_read_scheduler.md
# mem_read_scheduler

Read-side scheduler between the core's read masters (D-cache, I-cache, stream buffer) and the single memory read channel. Only one burst is in flight at a time. Demand misses are served ahead of prefetches. The prefetch master gets an aging boost so it cannot starve. Read data beats are steered back to the owning master by ID.

## Interface
Parameters:
- `NUM_MASTERS`, 3, number of read masters. Lower index has higher priority. Index `NUM_MASTERS-1` is the prefetch master.
- `ADDR_W`, 26, byte address width.
- `DATA_W`, 32, data beat width.
- `AGE_LIMIT`, 16, cycles a prefetch request may wait before it is forced to win (legal range 1..255).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `m_arvalid` in `NUM_MASTERS`: per-master request valid.
- `m_araddr` in `NUM_MASTERS*ADDR_W`: per-master burst address; master i occupies slice i.
- `m_arlen` in `NUM_MASTERS*4`: per-master burst length minus 1.
- `m_arready` out `NUM_MASTERS`: request accepted, one-hot.
- `m_rvalid` out `NUM_MASTERS`: data beat valid, one-hot to the owner.
- `m_rlast` out 1: last beat, broadcast.
- `m_rdata` out `DATA_W`: beat data, broadcast.
- `m_rready` in `NUM_MASTERS`: per-master beat ready.
- `ARVALID` out 1, `ARREADY` in 1, `ARID` out 4, `ARLEN` out 4, `ARADDR` out `ADDR_W`: downstream address channel.
- `RVALID` in 1, `RREADY` out 1, `RLAST` in 1, `RID` in 4, `RDATA` in `DATA_W`: downstream data channel.
- `rid_err` out 1: sticky flag, set when a beat arrives whose `RID` does not match the current owner.

## Operation
- FSM states:
  - `IDLE`: if any `m_arvalid` is set, pick a winner, pulse `m_arready[winner]` combinationally in the same cycle, register addr/len/owner, then go to `ADDR`.
  - `ADDR`: hold `ARVALID`=1, `ARID`=owner, `ARADDR`/`ARLEN` from the registers. On `ARVALID&&ARREADY`, go to `DATA`.
  - `DATA`: if `RID`==owner, then `m_rvalid[owner]`=`RVALID` and `RREADY`=`m_rready[owner]`. On `RVALID&&RREADY&&RLAST`, go to `IDLE`.
- Winner selection: the lowest-index master with `m_arvalid` set wins, unless the prefetch age counter equals `AGE_LIMIT`, in which case the prefetch master wins.
- Age counter (8 bits):
  - Increments each cycle the prefetch master is valid and not granted.
  - Saturates at `AGE_LIMIT`.
  - Clears on a prefetch grant or whenever prefetch `m_arvalid` is low, since prefetch may withdraw its request before grant.
- Demand masters must hold `m_arvalid`, addr and len stable until `m_arready`.
- RID mismatch in `DATA`:
  - Assert `RREADY`=1 to drain the beat and set `rid_err`.
  - Drive no `m_rvalid`.
  - Stay in `DATA`.
- `m_rdata`/`m_rlast` always mirror `RDATA`/`RLAST`.
- Reset in any state: return to `IDLE` and discard any in-flight burst. Memory is reset alongside the scheduler.

## Timing
- Reset values:
  - State `IDLE`.
  - All `m_arready`, `m_rvalid`, `ARVALID`, `RREADY` = 0.
  - `ARID`/`ARLEN`/`ARADDR` = 0.
  - `rid_err` = 0, age counter = 0.
- Request accepted in cycle t gives `ARVALID`=1 from t+1.
- `ARREADY` seen at cycle u gives `DATA` from u+1.
- Beat routing is combinational, 0 cycles.
- Last beat accepted at cycle v gives `IDLE` at v+1; a new grant is possible at v+1. Minimum gap between bursts is 1 cycle.
- Simultaneous requests in `IDLE` produce exactly one `m_arready` bit; the others wait with no loss.
- `m_arready` is never asserted outside `IDLE`.

## Configuration
- `MEM_SCHED_AGING_EN` defined: the age counter and forced prefetch win operate as described.
- `MEM_SCHED_AGING_EN` undefined: pure fixed priority, and `AGE_LIMIT` is ignored. The prefetch master may starve indefinitely, and the age counter logic is absent.

## Structure
- `mem_sched_pkg` holds:
  - The `sched_state_e` enum (`IDLE`, `ADDR`, `DATA`).
  - The `ID_W`=4 constant.
  - The `age_t` typedef (8 bits).
- One sub-module, `mem_sched_pick`: a combinational priority picker plus the aging override. It takes the valid vector and the age-saturated flag and outputs a one-hot grant and the winner index.
- The FSM, registers and beat steering stay in the top module.

## Test plan
- Single D-cache request: `m_arvalid[0]`=1, addr 0x100, len 3. `ARADDR`=0x100 and `ARID`=0 one cycle later. Four beats go to `m_rvalid[0]` only, then `IDLE`.
- All three valid at once: grant order is 0, 1, 2 across three bursts. `m_arready` is one-hot each time.
- Prefetch starvation with aging: masters 0 and 2 held valid continuously and `AGE_LIMIT`=4. Master 2 is granted once its counter reaches 4. Without `MEM_SCHED_AGING_EN`, master 2 is never granted.
- `ARREADY` held low 5 cycles: `ARVALID` and addr stay stable for 5 cycles, and no second `m_arready` occurs.
- Beat with `RID`=2 while the owner is 0: `rid_err`=1, `RREADY`=1, `m_rvalid`=0. The FSM remains in `DATA`.
- `rst_n` low during `DATA` beat 2: next cycle all outputs are at reset values, and a new request is granted in the first cycle after reset release.
